csr_regfile: RTL

//   Machine-mode CSR register file; the responder for CLINT's CSR write/read port and for the EX-stage CSR instructions.

---
 rtl/csr_regfile.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR register file shared by the EX stage and CLINT.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause plus the 2*DW-bit mcycle and
// minstret counters. It arbitrates two write ports, where CLINT wins on the
// same address, and forwards same-cycle writes to both read ports.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   inst_retire                    one instruction retired (minstret increment)
//   ex_we/ex_waddr/ex_wdata        EX-stage CSR write port
//   ex_raddr/ex_rdata              EX-stage CSR read port (combinational)
//   int_we/int_waddr/int_wdata     CLINT CSR write port
//   int_raddr/int_rdata            CLINT CSR read port (combinational)
//   csr_mtvec/csr_mepc/csr_mstatus committed register values for CLINT
//   global_int_en                  mstatus.MIE
module csr_regfile #(
  parameter int unsigned   DW        = 16,
  parameter int unsigned   AW        = 16,
  parameter logic [DW-1:0] MTVEC_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_retire,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [AW-1:0] ex_raddr,
  output logic [DW-1:0] ex_rdata,
  input  logic          int_we,
  input  logic [AW-1:0] int_waddr,
  input  logic [DW-1:0] int_wdata,
  input  logic [AW-1:0] int_raddr,
  output logic [DW-1:0] int_rdata,
  output logic [DW-1:0] csr_mtvec,
  output logic [DW-1:0] csr_mepc,
  output logic [DW-1:0] csr_mstatus,
  output logic          global_int_en
);

  localparam int unsigned   CW           = 2 * DW;
  localparam int unsigned   MIE_BIT      = 3;
  localparam logic [DW-1:0] MSTATUS_MASK = DW'(16'h0088);

  localparam logic [11:0] A_MSTATUS     = 12'h300;
  localparam logic [11:0] A_MIE         = 12'h304;
  localparam logic [11:0] A_MTVEC       = 12'h305;
  localparam logic [11:0] A_MSCRATCH    = 12'h340;
  localparam logic [11:0] A_MEPC        = 12'h341;
  localparam logic [11:0] A_MCAUSE      = 12'h342;
  localparam logic [11:0] A_MCYCLE_LO   = 12'hB00;
  localparam logic [11:0] A_MCYCLE_HI   = 12'hB80;
  localparam logic [11:0] A_MINSTRET_LO = 12'hB02;
  localparam logic [11:0] A_MINSTRET_HI = 12'hB82;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MSTATUS,
    SEL_MIE,
    SEL_MTVEC,
    SEL_MSCRATCH,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_MCYCLE_LO,
    SEL_MCYCLE_HI,
    SEL_MINSTRET_LO,
    SEL_MINSTRET_HI
  } csr_sel_e;

  logic [DW-1:0] mstatus_q, mstatus_d;
  logic [DW-1:0] mie_q, mie_d;
  logic [DW-1:0] mtvec_q, mtvec_d;
  logic [DW-1:0] mscratch_q, mscratch_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic [DW-1:0] mcause_q, mcause_d;
  logic [CW-1:0] mcycle_q, mcycle_d;
  logic [CW-1:0] minstret_q, minstret_d;

  csr_sel_e ex_wsel, int_wsel, ex_rsel, int_rsel;

  // Address decode; anything with nonzero bits above [11:0] is unmapped.
  function automatic csr_sel_e decode(input logic [AW-1:0] addr);
    csr_sel_e sel;
    sel = SEL_NONE;
    if ((addr >> 12) == '0) begin
      case (addr[11:0])
        A_MSTATUS:     sel = SEL_MSTATUS;
        A_MIE:         sel = SEL_MIE;
        A_MTVEC:       sel = SEL_MTVEC;
        A_MSCRATCH:    sel = SEL_MSCRATCH;
        A_MEPC:        sel = SEL_MEPC;
        A_MCAUSE:      sel = SEL_MCAUSE;
        A_MCYCLE_LO:   sel = SEL_MCYCLE_LO;
        A_MCYCLE_HI:   sel = SEL_MCYCLE_HI;
        A_MINSTRET_LO: sel = SEL_MINSTRET_LO;
        A_MINSTRET_HI: sel = SEL_MINSTRET_HI;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  // Only mstatus has non-storable bits.
  function automatic logic [DW-1:0] mask_wdata(input csr_sel_e sel, input logic [DW-1:0] data);
    return (sel == SEL_MSTATUS) ? (data & MSTATUS_MASK) : data;
  endfunction

  function automatic logic [DW-1:0] read_reg(input csr_sel_e sel);
    logic [DW-1:0] v;
    v = '0;
    case (sel)
      SEL_MSTATUS:     v = mstatus_q;
      SEL_MIE:         v = mie_q;
      SEL_MTVEC:       v = mtvec_q;
      SEL_MSCRATCH:    v = mscratch_q;
      SEL_MEPC:        v = mepc_q;
      SEL_MCAUSE:      v = mcause_q;
      SEL_MCYCLE_LO:   v = mcycle_q[DW-1:0];
      SEL_MCYCLE_HI:   v = mcycle_q[CW-1:DW];
      SEL_MINSTRET_LO: v = minstret_q[DW-1:0];
      SEL_MINSTRET_HI: v = minstret_q[CW-1:DW];
      default:         v = '0;
    endcase
    return v;
  endfunction

  // Read with forwarding of this cycle's write data, CLINT port first.
  function automatic logic [DW-1:0] read_port(input csr_sel_e rsel);
    logic [DW-1:0] v;
    if (rsel == SEL_NONE)       v = '0;
    else if (int_wsel == rsel)  v = mask_wdata(rsel, int_wdata);
    else if (ex_wsel == rsel)   v = mask_wdata(rsel, ex_wdata);
    else                        v = read_reg(rsel);
    return v;
  endfunction

  function automatic logic wr_hit(input csr_sel_e sel);
    return (int_wsel == sel) || (ex_wsel == sel);
  endfunction

  // New value for a DW-wide register; CLINT overrides EX on the same target.
  function automatic logic [DW-1:0] wr_val(input csr_sel_e sel, input logic [DW-1:0] cur);
    logic [DW-1:0] v;
    if (int_wsel == sel)     v = int_wdata;
    else if (ex_wsel == sel) v = ex_wdata;
    else                     v = cur;
    return v;
  endfunction

  // Port decode, gated by write enables.
  always_comb begin
    ex_wsel  = ex_we  ? decode(ex_waddr)  : SEL_NONE;
    int_wsel = int_we ? decode(int_waddr) : SEL_NONE;
    ex_rsel  = decode(ex_raddr);
    int_rsel = decode(int_raddr);
  end

  // Read ports.
  always_comb begin
    ex_rdata  = read_port(ex_rsel);
    int_rdata = read_port(int_rsel);
  end

  // Next-state for registers and counters.
  always_comb begin
    mstatus_d  = wr_val(SEL_MSTATUS, mstatus_q) & MSTATUS_MASK;
    mie_d      = wr_val(SEL_MIE, mie_q);
    mtvec_d    = wr_val(SEL_MTVEC, mtvec_q);
    mscratch_d = wr_val(SEL_MSCRATCH, mscratch_q);
    mepc_d     = wr_val(SEL_MEPC, mepc_q);
    mcause_d   = wr_val(SEL_MCAUSE, mcause_q);

    // A write to either half replaces that half and suppresses the increment.
    mcycle_d = mcycle_q + CW'(1);
    if (wr_hit(SEL_MCYCLE_LO) || wr_hit(SEL_MCYCLE_HI)) begin
      mcycle_d = {wr_val(SEL_MCYCLE_HI, mcycle_q[CW-1:DW]),
                  wr_val(SEL_MCYCLE_LO, mcycle_q[DW-1:0])};
    end

    minstret_d = minstret_q;
    if (wr_hit(SEL_MINSTRET_LO) || wr_hit(SEL_MINSTRET_HI)) begin
      minstret_d = {wr_val(SEL_MINSTRET_HI, minstret_q[CW-1:DW]),
                    wr_val(SEL_MINSTRET_LO, minstret_q[DW-1:0])};
    end else if (inst_retire) begin
      minstret_d = minstret_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign csr_mtvec     = mtvec_q;
  assign csr_mepc      = mepc_q;
  assign csr_mstatus   = mstatus_q;
  assign global_int_en = mstatus_q[MIE_BIT];

endmodule
